// File: rtl/dc_elim_pkg.sv
// dc_elim_pkg: shared types and sizing for the DC-elimination stage
package dc_elim_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LOG2_N = 10;
  function automatic int acc_w(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction
endpackage

// File: rtl/dc_estimate_ctrl_if.sv
// dc_estimate_ctrl_if: sample stream in, corrected stream and estimate status out
interface dc_estimate_ctrl_if #(parameter int DATA_W = 16);
  logic                     en;
  logic                     freeze;
  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] y_out;
  logic                     y_valid;
  logic signed [DATA_W-1:0] dc_est;
  logic                     dc_valid;
  logic                     upd_pulse;
  logic                     busy;
  modport master (output en, freeze, sample_in, sample_valid,
                  input  y_out, y_valid, dc_est, dc_valid, upd_pulse, busy);
  modport slave  (input  en, freeze, sample_in, sample_valid,
                  output y_out, y_valid, dc_est, dc_valid, upd_pulse, busy);
endinterface

// File: rtl/dc_estimate_ctrl_sat_sub.sv
// sat_sub: signed a - b clamped to the DATA_W range
module sat_sub #(parameter int DATA_W = 16) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_y
);
  logic signed [DATA_W:0] w_diff;
  logic                   w_ovf;
  assign w_diff = {i_a[DATA_W-1], i_a} - {i_b[DATA_W-1], i_b};
  assign w_ovf  = w_diff[DATA_W] != w_diff[DATA_W-1];
  assign o_y    = !w_ovf ? w_diff[DATA_W-1:0]
                : w_diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
endmodule

// File: rtl/dc_estimate_ctrl.sv
// dc_estimate_ctrl: block-averaged DC estimate and saturating DC removal
module dc_estimate_ctrl
  import dc_elim_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input logic              clk,
  input logic              rst,
  dc_estimate_ctrl_if.slave bus
);
  localparam int ACC_W = acc_w(DATA_W, LOG2_N);
  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [LOG2_N-1:0]        r_cnt;
  logic signed [DATA_W-1:0] r_dc_est;
  logic                     r_dc_valid;
  logic                     r_upd;
  logic signed [DATA_W-1:0] r_y;
  logic                     r_y_valid;
  logic signed [ACC_W-1:0]  w_sext;
  logic signed [DATA_W-1:0] w_dc_new;
  logic signed [DATA_W-1:0] w_y;
  logic                     w_take;
  assign w_sext   = {{LOG2_N{bus.sample_in[DATA_W-1]}}, bus.sample_in};
  assign w_dc_new = DATA_W'(r_acc >>> LOG2_N);
  assign w_take   = bus.en && bus.sample_valid;
  sat_sub #(.DATA_W(DATA_W)) u_sat (.i_a(bus.sample_in), .i_b(r_dc_est), .o_y(w_y));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_dc_est   <= '0;
      r_dc_valid <= 1'b0;
      r_upd      <= 1'b0;
      r_y        <= '0;
      r_y_valid  <= 1'b0;
    end else begin
      r_y       <= w_y;
      r_y_valid <= bus.sample_valid;
      r_upd     <= 1'b0;
      case (r_state)
        IDLE: if (bus.en) begin
          r_state <= ACCUM;
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        // the last sample of a block completes it even if en drops with it
        ACCUM: if (bus.sample_valid && &r_cnt) begin
          r_acc   <= r_acc + w_sext;
          r_state <= UPDATE;
        end else if (!bus.en) begin
          r_state <= IDLE;
        end else if (bus.sample_valid) begin
          r_acc <= r_acc + w_sext;
          r_cnt <= r_cnt + 1'b1;
        end
        UPDATE: begin
          if (!bus.freeze) begin
            r_dc_est   <= w_dc_new;
            r_dc_valid <= 1'b1;
            r_upd      <= 1'b1;
          end
          r_state <= bus.en ? ACCUM : IDLE;
          r_acc   <= w_take ? w_sext : '0;
          r_cnt   <= w_take ? LOG2_N'(1) : '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.y_out     = r_y;
  assign bus.y_valid   = r_y_valid;
  assign bus.dc_est    = r_dc_est;
  assign bus.dc_valid  = r_dc_valid;
  assign bus.upd_pulse = r_upd;
  assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_dc_estimate_ctrl.sv
// tb_dc_estimate_ctrl: directed and random checks against a block-average model
module tb_dc_estimate_ctrl;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  dc_estimate_ctrl_if #(.DATA_W(16)) bus ();
  dc_estimate_ctrl #(.DATA_W(16), .LOG2_N(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [35:0] w_obs;
  assign w_obs = {bus.y_out, bus.y_valid, bus.dc_est, bus.dc_valid, bus.upd_pulse, bus.busy};
  // reference: a list of the samples collected for the current block
  int m_y, m_dc;
  bit m_yv, m_dcv, m_pulse, m_act, m_upd;
  int blk[$];
  function automatic int clamp(input int d);
    return d > 32767 ? 32767 : d < -32768 ? -32768 : d;
  endfunction
  function automatic void model_reset();
    m_y = 0; m_dc = 0; m_yv = 0; m_dcv = 0; m_pulse = 0; m_act = 0; m_upd = 0;
    blk.delete();
  endfunction
  function automatic logic [35:0] m_pack();
    return {16'(m_y), m_yv, 16'(m_dc), m_dcv, m_pulse, m_act | m_upd};
  endfunction
  function automatic void model(input bit e, input bit f, input bit v, input int s);
    int sum, q;
    m_y = clamp(s - m_dc);
    m_yv = v;
    m_pulse = 0;
    if (m_upd) begin
      if (!f) begin
        sum = 0;
        foreach (blk[i]) sum += blk[i];
        q = sum / N;
        if (sum < 0 && q * N != sum) q--;
        m_dc = q; m_dcv = 1; m_pulse = 1;
      end
      blk.delete();
      m_upd = 0;
      m_act = e;
      if (e && v) blk.push_back(s);
    end else if (m_act) begin
      if (v && blk.size() == N - 1) begin blk.push_back(s); m_upd = 1; m_act = 0; end
      else if (!e) begin m_act = 0; blk.delete(); end
      else if (v) blk.push_back(s);
    end else if (e) begin
      m_act = 1;
      blk.delete();
    end
  endfunction
  task automatic cyc(input bit e, input bit f, input bit v, input int s);
    bus.en = e; bus.freeze = f; bus.sample_valid = v; bus.sample_in = 16'(s);
    @(posedge clk);
    model(e, f, v, s);
    #1;
  endtask
  task automatic test_reset();
    bus.en = 0; bus.freeze = 0; bus.sample_valid = 1; bus.sample_in = 16'd555;
    #2 rst = 1;
    #1 n_chk++;
    if (w_obs !== 36'h0) begin n_fail++; $display("FAIL reset_init: got %h exp %h", w_obs, 36'h0); end
    model_reset();
    #6 rst = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, i * 1000 - 1500);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL reset_idle[%0d]: got %h exp %h", i, w_obs, m_pack()); end
    end
  endtask
  task automatic test_basic();
    bit v[8] = '{0,1,1,1,1,0,1,1};
    int s[8] = '{0,100,102,98,104,0,110,90};
    foreach (v[i]) begin
      cyc(1, 0, v[i], s[i]);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL basic[%0d]: got %h exp %h", i, w_obs, m_pack()); end
      if (i == 5) begin
        n_chk++;
        if ({bus.dc_est, bus.upd_pulse, bus.dc_valid} !== {16'd101, 1'b1, 1'b1})
          begin n_fail++; $display("FAIL basic_dc: got %0d/%b/%b exp 101/1/1", $signed(bus.dc_est), bus.upd_pulse, bus.dc_valid); end
      end
      if (i == 6) begin
        n_chk++;
        if ({bus.y_out, bus.upd_pulse} !== {16'd9, 1'b0})
          begin n_fail++; $display("FAIL basic_y9: got %0d/%b exp 9/0", $signed(bus.y_out), bus.upd_pulse); end
      end
      if (i == 7) begin
        n_chk++;
        if (bus.y_out !== 16'(-11)) begin n_fail++; $display("FAIL basic_y-11: got %0d exp -11", $signed(bus.y_out)); end
      end
    end
  endtask
  task automatic test_neg_floor();
    bit e[8] = '{0,1,1,1,1,1,1,1};
    bit v[8] = '{0,0,1,1,1,1,0,1};
    int s[8] = '{0,0,-3,-3,-3,-2,0,0};
    foreach (v[i]) begin
      cyc(e[i], 0, v[i], s[i]);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL neg[%0d]: got %h exp %h", i, w_obs, m_pack()); end
      if (i == 6) begin
        n_chk++;
        if (bus.dc_est !== 16'(-3)) begin n_fail++; $display("FAIL neg_dc: got %0d exp -3", $signed(bus.dc_est)); end
      end
      if (i == 7) begin
        n_chk++;
        if (bus.y_out !== 16'd3) begin n_fail++; $display("FAIL neg_y: got %0d exp 3", $signed(bus.y_out)); end
      end
    end
  endtask
  task automatic test_saturation();
    bit e[16] = '{0,1,1,1,1,1,1,1, 0,1,1,1,1,1,1,1};
    bit v[16] = '{0,0,1,1,1,1,0,1, 0,0,1,1,1,1,0,1};
    int s[16] = '{0,0,-32768,-32768,-32768,-32768,0,32767, 0,0,100,100,100,100,0,-32768};
    foreach (v[i]) begin
      cyc(e[i], 0, v[i], s[i]);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL sat[%0d]: got %h exp %h", i, w_obs, m_pack()); end
      if (i == 7) begin
        n_chk++;
        if ({bus.dc_est, bus.y_out} !== {16'h8000, 16'h7fff})
          begin n_fail++; $display("FAIL sat_hi: got dc %0d y %0d exp -32768/32767", $signed(bus.dc_est), $signed(bus.y_out)); end
      end
      if (i == 15) begin
        n_chk++;
        if ({bus.dc_est, bus.y_out} !== {16'd100, 16'h8000})
          begin n_fail++; $display("FAIL sat_lo: got dc %0d y %0d exp 100/-32768", $signed(bus.dc_est), $signed(bus.y_out)); end
      end
    end
  endtask
  task automatic test_gaps();
    bit e[10] = '{0,1,1,1,1,1,1,1,1,1};
    bit v[10] = '{0,0,1,0,1,0,1,0,1,0};
    int s[10] = '{0,0,20,0,22,0,24,0,26,0};
    foreach (v[i]) begin
      cyc(e[i], 0, v[i], s[i]);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL gaps[%0d]: got %h exp %h", i, w_obs, m_pack()); end
      if (i == 9) begin
        n_chk++;
        if ({bus.dc_est, bus.upd_pulse} !== {16'd23, 1'b1})
          begin n_fail++; $display("FAIL gaps_dc: got %0d/%b exp 23/1", $signed(bus.dc_est), bus.upd_pulse); end
      end
    end
  endtask
  task automatic test_back_to_back();
    bit e[11] = '{0,1,1,1,1,1,1,1,1,1,1};
    bit v[11] = '{0,0,1,1,1,1,1,1,1,1,0};
    int s[11] = '{0,0,50,50,50,50,8,8,8,8,0};
    foreach (v[i]) begin
      cyc(e[i], 0, v[i], s[i]);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL b2b[%0d]: got %h exp %h", i, w_obs, m_pack()); end
      if (i == 6) begin
        n_chk++;
        if ({bus.dc_est, bus.y_out} !== {16'd50, 16'(-15)})
          begin n_fail++; $display("FAIL b2b_old_est: got dc %0d y %0d exp 50/-15", $signed(bus.dc_est), $signed(bus.y_out)); end
      end
      if (i == 10) begin
        n_chk++;
        if (bus.dc_est !== 16'd8) begin n_fail++; $display("FAIL b2b_dc: got %0d exp 8", $signed(bus.dc_est)); end
      end
    end
  endtask
  task automatic test_en_drop();
    bit e[17] = '{0,1,1,1,0,0,1,1,1,1,1,1,1,1,1,0,0};
    bit v[17] = '{0,0,1,1,0,0,0,1,1,1,1,0,1,1,1,1,0};
    int s[17] = '{0,0,500,500,0,0,0,4,4,4,4,0,6,6,6,6,0};
    foreach (v[i]) begin
      cyc(e[i], 0, v[i], s[i]);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL en_drop[%0d]: got %h exp %h", i, w_obs, m_pack()); end
      if (i == 4) begin
        n_chk++;
        if ({bus.dc_est, bus.busy} !== {16'd8, 1'b0})
          begin n_fail++; $display("FAIL en_abort: got %0d/%b exp 8/0", $signed(bus.dc_est), bus.busy); end
      end
      if (i == 11) begin
        n_chk++;
        if (bus.dc_est !== 16'd4) begin n_fail++; $display("FAIL en_restart: got %0d exp 4", $signed(bus.dc_est)); end
      end
      if (i == 16) begin
        n_chk++;
        if ({bus.dc_est, bus.upd_pulse, bus.busy} !== {16'd6, 1'b1, 1'b0})
          begin n_fail++; $display("FAIL en_last: got %0d/%b/%b exp 6/1/0", $signed(bus.dc_est), bus.upd_pulse, bus.busy); end
      end
    end
  endtask
  task automatic test_freeze();
    bit f[12] = '{0,0,0,1,0,1,1,1,1,0,1,0};
    bit v[12] = '{0,0,1,1,1,1,0,1,1,1,1,0};
    int s[12] = '{0,0,40,40,40,40,0,12,12,12,12,0};
    foreach (v[i]) begin
      cyc(i != 0, f[i], v[i], s[i]);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL freeze[%0d]: got %h exp %h", i, w_obs, m_pack()); end
      if (i == 6) begin
        n_chk++;
        if ({bus.dc_est, bus.upd_pulse, bus.busy} !== {16'd6, 1'b0, 1'b1})
          begin n_fail++; $display("FAIL freeze_hold: got %0d/%b/%b exp 6/0/1", $signed(bus.dc_est), bus.upd_pulse, bus.busy); end
      end
      if (i == 11) begin
        n_chk++;
        if ({bus.dc_est, bus.upd_pulse} !== {16'd12, 1'b1})
          begin n_fail++; $display("FAIL freeze_resume: got %0d/%b exp 12/1", $signed(bus.dc_est), bus.upd_pulse); end
      end
    end
  endtask
  task automatic test_reset_mid();
    bit v[4] = '{0,0,1,1};
    foreach (v[i]) cyc(i != 0, 0, v[i], 7 + i);
    #2 rst = 1;
    #1 n_chk++;
    if (w_obs !== 36'h0) begin n_fail++; $display("FAIL reset_mid: got %h exp %h", w_obs, 36'h0); end
    model_reset();
    #1 rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 300);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL reset_after[%0d]: got %h exp %h", i, w_obs, m_pack()); end
    end
  endtask
  task automatic test_random();
    int s;
    for (int i = 0; i < 400; i++) begin
      s = int'($signed(16'($urandom)));
      if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 1) ? 32767 : -32768;
      else if ($urandom_range(0, 1) == 0) s = int'($urandom_range(0, 200)) - 100;
      cyc($urandom_range(0, 24) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7, s);
      n_chk++;
      if (w_obs !== m_pack()) begin n_fail++; $display("FAIL random[%0d]: got %h exp %h", i, w_obs, m_pack()); end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_neg_floor();
    test_saturation();
    test_gaps();
    test_back_to_back();
    test_en_drop();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
